// File: rtl/dram_cmd_pkg.sv
// Command encodings, bank states and default latencies shared by the DRAM
// responder and the memory controller.
package dram_cmd_pkg;

  typedef enum logic [3:0] {
    CMD_NOP       = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVATE  = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_ILLEGAL   = 4'b0110,
    CMD_DESELECT  = 4'b1000
  } dram_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVATING,
    ST_ACTIVE,
    ST_READING,
    ST_WRITING,
    ST_PRECHARGING,
    ST_REFRESHING
  } bank_state_e;

  localparam int DEF_TRCD           = 5;
  localparam int DEF_TCL            = 5;
  localparam int DEF_TPRE           = 10;
  localparam int DEF_TREFRESH       = 10;
  localparam int DEF_REFRESH_WINDOW = 200;

  // {cs,ras,cas,we}; cs high deselects regardless of the other bits
  function automatic dram_cmd_e decode_cmd(input logic [3:0] bits);
    dram_cmd_e c;
    if (bits[3]) c = CMD_DESELECT;
    else begin
      case (bits[2:0])
        3'b000:  c = CMD_NOP;
        3'b001:  c = CMD_REFRESH;
        3'b010:  c = CMD_PRECHARGE;
        3'b011:  c = CMD_ACTIVATE;
        3'b100:  c = CMD_WRITE;
        3'b101:  c = CMD_READ;
        default: c = CMD_ILLEGAL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/dram_bank_responder_if.sv
// Command/response bus between the memory controller (master) and the
// DRAM bank responder (slave).
interface dram_bank_responder_if;
  logic        cs;
  logic        ras;
  logic        cas;
  logic        we;
  logic [31:0] request_addr;
  logic [31:0] request_data;
  logic        response_complete;
  logic [31:0] response_data;

  modport master (
    output cs, ras, cas, we, request_addr, request_data,
    input  response_complete, response_data
  );

  modport slave (
    input  cs, ras, cas, we, request_addr, request_data,
    output response_complete, response_data
  );
endinterface

// File: rtl/dram_storage_array.sv
// Single-port synchronous word RAM with one-cycle registered read; contents
// are never reset.
module dram_storage_array #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dram_bank_responder.sv
// Single-bank DRAM responder: decodes the command bus, tracks the open row and
// applies per-command latency. DRAM_RESP_REFRESH_CHECK_EN adds a refresh watchdog.
module dram_bank_responder
  import dram_cmd_pkg::*;
#(
  parameter int ROW_BITS       = 4,
  parameter int COL_BITS       = 4,
  parameter int tRCD           = DEF_TRCD,
  parameter int tCL            = DEF_TCL,
  parameter int tPRE           = DEF_TPRE,
  parameter int tREFRESH       = DEF_TREFRESH,
  parameter int REFRESH_WINDOW = DEF_REFRESH_WINDOW
) (
  input  logic                    clk,
  input  logic                    rst,
  dram_bank_responder_if.slave    bus,
  output logic                    row_open,
  output logic [ROW_BITS-1:0]     open_row,
  output logic                    protocol_err,
  output logic                    refresh_timeout
);
  localparam int AW      = ROW_BITS + COL_BITS;
  localparam int MAX_A   = (tRCD > tCL) ? tRCD : tCL;
  localparam int MAX_B   = (tPRE > tREFRESH) ? tPRE : tREFRESH;
  localparam int MAX_LAT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  bank_state_e         r_state, w_nxt_state;
  dram_cmd_e           r_prev_cmd, w_cmd;
  logic [CNT_W-1:0]    r_cnt, w_nxt_cnt;
  logic                r_row_open, w_base_open;
  logic [ROW_BITS-1:0] r_open_row;
  logic [COL_BITS-1:0] r_col, w_rd_col;
  logic [31:0]         r_wdata, r_resp_data, w_ram_q;
  logic                r_err, r_err_pulse;
  logic                w_accept, w_busy, w_done, w_set_err, w_err_pulse;
  logic                w_ld_row, w_ld_col, w_we, w_re, w_rd_done;
  logic [AW-1:0]       w_ram_addr;
  logic                w_unused;

  wire [ROW_BITS-1:0] w_addr_row = bus.request_addr[AW-1:COL_BITS];
  wire [COL_BITS-1:0] w_addr_col = bus.request_addr[COL_BITS-1:0];

  assign w_unused = ^bus.request_addr[31:AW];
  assign w_cmd    = decode_cmd({bus.cs, bus.ras, bus.cas, bus.we});
  assign w_accept = (w_cmd != r_prev_cmd);
  assign w_busy   = (r_state != ST_IDLE) && (r_state != ST_ACTIVE);
  assign w_done   = !rst && w_busy && (r_cnt == CNT_W'(1));

  // Completion lands first; a command arriving mid-operation aborts it and is
  // decoded against the stable state (row_open only moves on completion).
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = w_busy ? r_cnt - CNT_W'(1) : r_cnt;
    w_base_open = r_row_open;
    w_set_err   = 1'b0;
    w_err_pulse = 1'b0;
    w_ld_row    = 1'b0;
    w_ld_col    = 1'b0;
    if (w_done) begin
      case (r_state)
        ST_ACTIVATING:  begin w_nxt_state = ST_ACTIVE; w_base_open = 1'b1; end
        ST_PRECHARGING: begin w_nxt_state = ST_IDLE;   w_base_open = 1'b0; end
        ST_REFRESHING:  w_nxt_state = ST_IDLE;
        default:        w_nxt_state = ST_ACTIVE;
      endcase
    end
    if (w_accept && w_cmd != CMD_NOP && w_cmd != CMD_DESELECT) begin
      if (w_busy && !w_done) w_set_err = 1'b1;
      w_nxt_state = w_base_open ? ST_ACTIVE : ST_IDLE;
      case (w_cmd)
        CMD_ACTIVATE:
          if (!w_base_open) begin
            w_nxt_state = ST_ACTIVATING; w_nxt_cnt = CNT_W'(tRCD); w_ld_row = 1'b1;
          end else w_err_pulse = 1'b1;
        CMD_READ:
          if (w_base_open && w_addr_row == r_open_row) begin
            w_nxt_state = ST_READING; w_nxt_cnt = CNT_W'(tCL); w_ld_col = 1'b1;
          end else w_err_pulse = 1'b1;
        CMD_WRITE:
          if (w_base_open && w_addr_row == r_open_row) begin
            w_nxt_state = ST_WRITING; w_nxt_cnt = CNT_W'(tCL); w_ld_col = 1'b1;
          end else w_err_pulse = 1'b1;
        CMD_PRECHARGE: begin
          w_nxt_state = ST_PRECHARGING; w_nxt_cnt = CNT_W'(tPRE);
        end
        CMD_REFRESH:
          if (!w_base_open) begin
            w_nxt_state = ST_REFRESHING; w_nxt_cnt = CNT_W'(tREFRESH);
          end else w_err_pulse = 1'b1;
        default: w_err_pulse = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_prev_cmd  <= CMD_DESELECT;
      r_row_open  <= 1'b0;
      r_open_row  <= '0;
      r_col       <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_err_pulse <= 1'b0;
      r_resp_data <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_prev_cmd  <= w_cmd;
      r_row_open  <= w_base_open;
      r_err       <= r_err | w_set_err | w_err_pulse;
      r_err_pulse <= w_err_pulse;
      if (w_ld_row) r_open_row <= w_addr_row;
      if (w_ld_col) begin
        r_col   <= w_addr_col;
        r_wdata <= bus.request_data;
      end
      if (w_rd_done) r_resp_data <= w_ram_q;
    end
  end

  // Array read goes out one cycle ahead of the READ pulse; with tCL==1 that
  // is the acceptance cycle itself, and a write completing then takes the port.
  assign w_rd_done  = w_done && (r_state == ST_READING);
  assign w_we       = w_done && (r_state == ST_WRITING);
  assign w_re       = !rst && ((r_state == ST_READING && r_cnt == CNT_W'(2)) ||
                               (tCL == 1 && w_ld_col && w_cmd == CMD_READ));
  assign w_rd_col   = w_ld_col ? w_addr_col : r_col;
  assign w_ram_addr = w_we ? {r_open_row, r_col} : {r_open_row, w_rd_col};

  dram_storage_array #(.AW(AW), .DW(32)) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

  assign bus.response_complete = w_done || (r_err_pulse && !rst);
  assign bus.response_data     = w_rd_done ? w_ram_q : r_resp_data;
  assign row_open              = r_row_open;
  assign open_row              = r_open_row;
  assign protocol_err          = r_err;

`ifdef DRAM_RESP_REFRESH_CHECK_EN
  localparam int AGE_W = $clog2(REFRESH_WINDOW + 1);
  logic [AGE_W-1:0] r_ref_age;
  logic             r_ref_to;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_age <= '0;
      r_ref_to  <= 1'b0;
    end else begin
      if (w_accept && w_cmd == CMD_REFRESH) r_ref_age <= '0;
      else if (r_ref_age != AGE_W'(REFRESH_WINDOW)) r_ref_age <= r_ref_age + AGE_W'(1);
      if (r_ref_age == AGE_W'(REFRESH_WINDOW)) r_ref_to <= 1'b1;
    end
  end

  assign refresh_timeout = r_ref_to;
`else
  localparam int unused_refresh_window = REFRESH_WINDOW;
  assign refresh_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dram_bank_responder.sv
// Directed + randomized bench for dram_bank_responder with a transaction-level
// model (shadow memory, open-row tracking, expected pulse latency).
module tb_dram_bank_responder;
  import dram_cmd_pkg::*;

  localparam int TRCD = 5, TCL = 5, TPRE = 10, TREF = 10;
  localparam logic [3:0] C_DES = 4'b1111, C_NOP = 4'b0000, C_ACT = 4'b0011,
                         C_RD = 4'b0101, C_WR = 4'b0100, C_PRE = 4'b0010,
                         C_REF = 4'b0001, C_BAD = 4'b0110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       row_open, protocol_err, refresh_timeout;
  logic [3:0] open_row;

  dram_bank_responder_if bus();

  dram_bank_responder #(
    .ROW_BITS(4), .COL_BITS(4), .tRCD(TRCD), .tCL(TCL), .tPRE(TPRE),
    .tREFRESH(TREF), .REFRESH_WINDOW(200)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .row_open        (row_open),
    .open_row        (open_row),
    .protocol_err    (protocol_err),
    .refresh_timeout (refresh_timeout)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  logic [31:0] shadow [256];
  bit          valid  [256];
  bit          m_open;
  logic [3:0]  m_row;
  logic        m_err;
  logic [31:0] m_resp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    {bus.cs, bus.ras, bus.cas, bus.we} = c;
    bus.request_addr = a;
    bus.request_data = d;
  endtask

  // samples the current cycle, then moves to just after the next rising edge
  task automatic step(output logic p);
    @(negedge clk);
    p = bus.response_complete;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] d, input int lat, input int hold);
    int   first = -1;
    int   cnt = 0;
    int   n;
    logic p;
    n = (hold > lat + 2) ? hold : lat + 2;
    drive(c, a, d);
    for (int i = 0; i <= n; i++) begin
      if (i == n) drive(C_NOP, a, d);
      step(p);
      if (p === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk({tag, " latency"}, first, lat);
    chk({tag, " pulses"}, cnt, 1);
  endtask

  task automatic do_reset();
    logic p;
    rst = 1'b1;
    drive(C_DES, 0, 0);
    step(p);
    step(p);
    rst = 1'b0;
    m_open = 0; m_err = 0; m_resp = '0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, " row_open"}, row_open, m_open);
    if (m_open) chk({tag, " open_row"}, open_row, m_row);
    chk({tag, " err"}, protocol_err, m_err);
    chk({tag, " data"}, bus.response_data, m_resp);
  endtask

  initial begin
    int          r, first, cnt;
    logic        p;
    logic [3:0]  row, col;
    logic [7:0]  a;
    logic [31:0] d;

    do_reset();
    chk("rst complete", bus.response_complete, 0);
    chk("rst data", bus.response_data, 0);
    chk("rst row_open", row_open, 0);
    chk("rst open_row", open_row, 0);
    chk("rst err", protocol_err, 0);
    chk("rst refresh_timeout", refresh_timeout, 0);

    // write/read round trip
    issue("act3", C_ACT, 32'h30, 0, TRCD, 0);
    m_open = 1; m_row = 4'd3;
    chk_state("act3");
    issue("wr35", C_WR, 32'h35, 32'hDEADBEEF, TCL, 0);
    shadow[8'h35] = 32'hDEADBEEF; valid[8'h35] = 1;
    issue("rd35", C_RD, 32'h35, 0, TCL, 0);
    m_resp = 32'hDEADBEEF;
    chk_state("rd35");
    issue("rd35 held", C_RD, 32'h35, 0, TCL, 20);
    issue("pre", C_PRE, 0, 0, TPRE, 0);
    m_open = 0;
    chk_state("pre");

    // randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      col = 4'($urandom);
      d = $urandom;
      if (!m_open) begin
        if (r < 6) begin
          row = 4'($urandom);
          issue("r act", C_ACT, {24'h0, row, 4'h0}, 0, TRCD, 0);
          m_open = 1; m_row = row;
        end else if (r == 6) issue("r ref", C_REF, 0, 0, TREF, 0);
        else if (r == 7) issue("r pre idle", C_PRE, 0, 0, TPRE, 0);
        else if (r == 8) begin
          issue("r rd closed", C_RD, {24'h0, 4'($urandom), col}, 0, 1, 0);
          m_err = 1;
        end else begin
          issue("r bad", C_BAD, 0, 0, 1, 0);
          m_err = 1;
        end
      end else begin
        a = {m_row, col};
        if (r < 3 || (r < 6 && !valid[a])) begin
          issue("r wr", C_WR, {24'h0, a}, d, TCL, 0);
          shadow[a] = d; valid[a] = 1;
        end else if (r < 6) begin
          issue("r rd", C_RD, {24'h0, a}, 0, TCL, 0);
          m_resp = shadow[a];
        end else if (r == 6) begin
          issue("r pre", C_PRE, 0, 0, TPRE, 0);
          m_open = 0;
        end else if (r == 7) begin
          issue("r act open", C_ACT, {24'h0, a}, 0, 1, 0);
          m_err = 1;
        end else if (r == 8) begin
          issue("r ref open", C_REF, 0, 0, 1, 0);
          m_err = 1;
        end else begin
          issue("r wr wrong row", C_WR, {24'h0, m_row + 4'd1, col}, d, 1, 0);
          m_err = 1;
        end
      end
      chk_state("rand");
    end

    // read to a row that is not open
    do_reset();
    chk_state("rst2");
    issue("act3b", C_ACT, 32'h30, 0, TRCD, 0);
    m_open = 1; m_row = 4'd3;
    issue("wr35b", C_WR, 32'h35, 32'hCAFEF00D, TCL, 0);
    issue("rd35b", C_RD, 32'h35, 0, TCL, 0);
    m_resp = 32'hCAFEF00D;
    chk_state("rd35b");
    issue("rd45 wrong row", C_RD, 32'h45, 0, 1, 0);
    m_err = 1;
    chk_state("rd45");
    issue("rd35 after err", C_RD, 32'h35, 0, TCL, 0);
    chk_state("rd35 after err");

    // write aborted by PRECHARGE two cycles after acceptance
    do_reset();
    issue("act3c", C_ACT, 32'h30, 0, TRCD, 0);
    m_open = 1;
    cnt = 0; first = -1;
    drive(C_WR, 32'h35, 32'h11111111);
    step(p); if (p === 1'b1) cnt++;
    step(p); if (p === 1'b1) cnt++;
    drive(C_PRE, 0, 0);
    for (int i = 0; i <= 12; i++) begin
      if (i == 12) drive(C_NOP, 0, 0);
      step(p);
      if (p === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk("abort pre latency", first, TPRE);
    chk("abort pulses", cnt, 1);
    m_open = 0; m_err = 1;
    chk_state("abort");
    issue("act3d", C_ACT, 32'h30, 0, TRCD, 0);
    m_open = 1;
    issue("rd35 old", C_RD, 32'h35, 0, TCL, 0);
    m_resp = 32'hCAFEF00D;
    chk_state("rd35 old");
    issue("pre2", C_PRE, 0, 0, TPRE, 0);

    // reset during ACTIVATING
    cnt = 0;
    drive(C_ACT, 32'h50, 0);
    step(p); if (p === 1'b1) cnt++;
    step(p); if (p === 1'b1) cnt++;
    rst = 1'b1;
    drive(C_NOP, 0, 0);
    step(p); if (p === 1'b1) cnt++;
    rst = 1'b0;
    chk("midrst row_open", row_open, 0);
    chk("midrst open_row", open_row, 0);
    chk("midrst err", protocol_err, 0);
    chk("midrst data", bus.response_data, 0);
    chk("midrst complete", bus.response_complete, 0);
    for (int i = 0; i < 10; i++) begin
      step(p);
      if (p === 1'b1) cnt++;
    end
    chk("midrst pulses", cnt, 0);
    m_open = 0; m_err = 0; m_resp = '0;

    // refresh and the refresh watchdog
    issue("ref", C_REF, 0, 0, TREF, 0);
    chk_state("ref");
    for (int i = 0; i < 177; i++) step(p);
    chk("refresh_timeout early", refresh_timeout, 0);
    for (int i = 0; i < 20; i++) step(p);
`ifdef DRAM_RESP_REFRESH_CHECK_EN
    chk("refresh_timeout late", refresh_timeout, 1);
`else
    chk("refresh_timeout late", refresh_timeout, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dram_bank_responder.md
# dram_bank_responder

Memory-side counterpart of the controller's command interface: a single-bank DRAM responder that decodes the (cs, ras, cas, we) command bus, tracks open-row state, applies per-command latency, and returns `response_complete` / `response_data`. It sits where the DRAM device sits, directly across from the memory controller. It serves as the simulation/FPGA memory model and as a protocol checker for the controller.

## Interface
- `ROW_BITS`, 4: row address width; row = `request_addr[ROW_BITS+COL_BITS-1:COL_BITS]`
- `COL_BITS`, 4: column width; column = `request_addr[COL_BITS-1:0]`; storage = 2^(ROW_BITS+COL_BITS) 32-bit words
- `tRCD`, 5: ACTIVATE latency in cycles, ≥1
- `tCL`, 5: READ/WRITE latency in cycles, ≥1
- `tPRE`, 10: PRECHARGE latency in cycles, ≥1
- `tREFRESH`, 10: REFRESH latency in cycles, ≥1
- `REFRESH_WINDOW`, 200: maximum cycles between REFRESH commands. Used only with the refresh check.

- `clk` in 1: clock, rising edge
- `rst` in 1: reset rst, synchronous, active-high
- `cs`, `ras`, `cas`, `we` in 1 each: command bus
- `request_addr` in 32: row/column address
- `request_data` in 32: write data
- `response_complete` out 1: one-cycle completion pulse
- `response_data` out 32: last read data, held
- `row_open` out 1: a row is open
- `open_row` out ROW_BITS: the open row, valid when `row_open` is high
- `protocol_err` out 1: sticky illegal-command flag
- `refresh_timeout` out 1: sticky missed-refresh flag

## Operation
- Command decode uses {cs,ras,cas,we}:
  - 1xxx DESELECT
  - 0000 NOP
  - 0011 ACTIVATE
  - 0101 READ
  - 0100 WRITE
  - 0010 PRECHARGE
  - 0001 REFRESH
  - 0110 and 0111 ILLEGAL
- Commands are level-held by the controller. A command is accepted only on a change of the registered previous command, `prev_cmd`, which resets to DESELECT.
- FSM states: IDLE, ACTIVATING, ACTIVE, READING, WRITING, PRECHARGING, REFRESHING.
  - IDLE →ACTIVATE→ ACTIVATING: row latched from `request_addr`.
  - ACTIVATING → ACTIVE on completion: `row_open`=1.
  - ACTIVE →READ→ READING: column latched. On completion, `response_data` ← mem[{open_row,col}]; return to ACTIVE.
  - ACTIVE →WRITE→ WRITING: column and `request_data` latched at acceptance. On completion, mem[{open_row,col}] ← data; return to ACTIVE.
  - Any idle state →PRECHARGE→ PRECHARGING. On completion, `row_open`=0 → IDLE. PRECHARGE with no row open is legal.
  - IDLE →REFRESH→ REFRESHING → IDLE on completion.
- Illegal cases set `protocol_err` and the command is ignored:
  - READ or WRITE with no row open, or with the address row ≠ `open_row`
  - ACTIVATE or REFRESH while a row is open
  - ILLEGAL encodings
- An ignored command still pulses `response_complete` one cycle after acceptance, so the controller never hangs.
- A new non-DESELECT/NOP command accepted while busy sets `protocol_err` and aborts the current operation: a pending write is not committed, and the state reverts to its pre-command value. The new command is then decoded normally.
- DESELECT and NOP are never errors. An in-flight operation continues through them.
- `protocol_err` and `refresh_timeout` clear only on `rst`. Storage is not reset.

## Timing
- A command first present in cycle c (accepted at the end of c) raises `response_complete` high in cycle c+tX for exactly one cycle, where tX is the command's latency parameter.
- `response_data` updates in the same cycle as the READ completion pulse and holds until the next READ completes.
- A WRITE completion followed by a READ to the same address returns the new data.
- The latency down-counter width is $clog2(max latency)+1.
- Reset values:
  - `response_complete`=0, `response_data`=0
  - `row_open`=0, `open_row`=0
  - `protocol_err`=0, `refresh_timeout`=0
  - state IDLE
- `rst` asserted mid-operation abandons that operation. No write is committed and no pulse is issued.

## Configuration
- `DRAM_RESP_REFRESH_CHECK_EN` defined:
  - A refresh-age counter resets on each REFRESH acceptance and on `rst`.
  - When the age reaches `REFRESH_WINDOW` without a REFRESH, `refresh_timeout` sets (sticky).
  - REFRESH acceptance does not clear the flag.
- Not defined: no counter is built and `refresh_timeout` is tied 0.

## Structure
- Package `dram_cmd_pkg` holds:
  - the `dram_cmd_e` enum of the 4-bit encodings
  - the `bank_state_e` enum
  - the `decode_cmd` function
  - the default latency constants, shared with the controller
- Sub-module `dram_storage_array`: single-port synchronous RAM, 32-bit words, depth 2^(ROW_BITS+COL_BITS), write-enable plus read-enable, one-cycle read. The responder issues the array read one cycle before the READ completion pulse.

## Test plan
- Write/read round trip, defaults:
  - ACTIVATE row 3 (addr 0x30) at cycle 0 → pulse at cycle 5, `row_open`=1, `open_row`=3.
  - WRITE 0xDEADBEEF to 0x35 → pulse 5 cycles later.
  - READ 0x35 → pulse 5 cycles later with `response_data`=0xDEADBEEF.
  - PRECHARGE → pulse 10 cycles later, `row_open`=0.
- Level-held command: hold READ for 20 cycles → exactly one pulse.
- READ to addr 0x45 while row 3 is open → `protocol_err`=1, pulse next cycle, `response_data` unchanged, memory unchanged.
- WRITE accepted, then PRECHARGE at acceptance+2 → `protocol_err`=1, the write is not committed (a later read returns the old value), PRECHARGE completes normally.
- Refresh: REFRESH with no row open → pulse after 10 cycles. With the macro and no REFRESH for 200 cycles → `refresh_timeout`=1. Without the macro it stays 0.
- `rst` asserted during ACTIVATING → all outputs return to reset values next cycle, and no pulse is issued.
